// File: rtl/pipeline_trace_gen_if.sv
// rtl/pipeline_trace_gen_if.sv - retire-record stream between trace generator and its consumer
interface pipeline_trace_gen_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [7:0]  rec_id;
  logic [15:0] rec_pc;
  logic [15:0] rec_instr;
  logic        rec_we;
  logic [3:0]  rec_reg;
  logic [15:0] rec_data;
  logic [15:0] rec_cycle;

  modport master (
    output rec_valid, rec_id, rec_pc, rec_instr, rec_we, rec_reg, rec_data, rec_cycle,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_id, rec_pc, rec_instr, rec_we, rec_reg, rec_data, rec_cycle,
    output rec_ready
  );
endinterface

// File: rtl/pipeline_trace_gen.sv
// rtl/pipeline_trace_gen.sv - tags D/X/M/W pipeline slots and buffers one retire record per WB instruction
// Define TRACE_CYCLE_EN to stamp each record with a free-running 16-bit cycle count.
module pipeline_trace_gen #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        IF_flush_i,
  input  logic                        ID_flush_i,
  input  logic [15:0]                 fetch_pc_i,
  input  logic [15:0]                 fetch_instr_i,
  input  logic                        wb_we_i,
  input  logic [3:0]                  wb_reg_i,
  input  logic [15:0]                 wb_data_i,
  pipeline_trace_gen_if.master        rec,
  output logic [7:0]                  drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0] occupancy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        valid;
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] instr;
  } slot_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
  } rec_t;

  slot_t         d_q, d_d, x_q, x_d, m_q, w_q;
  logic [7:0]    next_id_q, next_id_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  rec_t          mem_q [FIFO_DEPTH];
  rec_t          head;
  logic          kill, push, pop, full, empty, push_ok;

  // An ID_flush kills the youngest issued tag, so its id is handed back to keep retired ids gap-free.
  always_comb begin
    d_d       = d_q;
    x_d       = x_q;
    x_d.valid = 1'b0;
    next_id_d = next_id_q;
    kill      = !stall_i && ID_flush_i && d_q.valid;
    if (!stall_i) begin
      x_d       = d_q;
      x_d.valid = d_q.valid && !ID_flush_i;
      d_d.valid = !IF_flush_i;
      d_d.id    = next_id_q - {7'd0, kill};
      d_d.pc    = fetch_pc_i;
      d_d.instr = fetch_instr_i;
      next_id_d = next_id_q - {7'd0, kill} + {7'd0, !IF_flush_i};
    end
  end

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    push     = w_q.valid;
    pop      = !empty && rec.rec_ready;
    push_ok  = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    drop_d   = drop_q;
    if (push && full && !pop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      x_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      next_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
    end else begin
      d_q       <= d_d;
      x_q       <= x_d;
      m_q       <= x_q;
      w_q       <= m_q;
      next_id_q <= next_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {w_q.id, w_q.pc, w_q.instr, wb_we_i, wb_reg_i, wb_data_i};
    end
  end

  assign head          = empty ? '0 : mem_q[rd_ptr_q];
  assign rec.rec_valid = !empty;
  assign rec.rec_id    = head.id;
  assign rec.rec_pc    = head.pc;
  assign rec.rec_instr = head.instr;
  assign rec.rec_we    = head.we;
  assign rec.rec_reg   = head.rd;
  assign rec.rec_data  = head.data;
  assign drop_cnt_o    = drop_q;
  assign occupancy_o   = count_q;

`ifdef TRACE_CYCLE_EN
  logic [15:0] cycle_q;
  logic [15:0] cyc_mem_q [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  // The stamp is the count the push edge produces, i.e. the cycle the record first becomes visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      cyc_mem_q[wr_ptr_q] <= cycle_q + 16'd1;
    end
  end

  assign rec.rec_cycle = empty ? 16'd0 : cyc_mem_q[rd_ptr_q];
`else
  assign rec.rec_cycle = 16'd0;
`endif
endmodule
